// File: rtl/uart_word_tx.sv
// Word-oriented UART transmitter: 32-bit words are queued in a small FIFO and sent
// as four 8N(STOP_BITS) frames, most significant byte and most significant bit first.
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              wdata,
  input  logic                     wvalid,
  output logic                     wready,
  output logic                     txd,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] STOP_LAST  = SW'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // word FIFO
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          push;
  logic          pop;

  // serializer
  state_t        state_reg, state_next;
  logic [31:0]   shifter_reg, shifter_next;
  logic [1:0]    byte_idx_reg, byte_idx_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [CW-1:0] clk_cnt_reg, clk_cnt_next;
  logic [SW-1:0] stop_cnt_reg, stop_cnt_next;
  logic          txd_reg, txd_next;
  logic          busy_reg, busy_next;
  logic          tick;
  logic [7:0]    cur_byte;

  assign wready     = (count_reg < FULL_COUNT);
  assign push       = wvalid && wready;
  assign txd        = txd_reg;
  assign busy       = busy_reg;
  assign fifo_count = count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW + 1)'(1);
      2'b01:   count_next = count_reg - (AW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  assign tick = (clk_cnt_reg == CNT_LAST);

  always_comb begin
    state_next    = state_reg;
    shifter_next  = shifter_reg;
    byte_idx_next = byte_idx_reg;
    bit_idx_next  = bit_idx_reg;
    clk_cnt_next  = clk_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    pop           = 1'b0;

    // the bit-period counter only runs while a frame is on the line
    if (state_reg != IDLE) begin
      clk_cnt_next = tick ? '0 : clk_cnt_reg + CW'(1);
    end

    case (state_reg)
      IDLE: begin
        clk_cnt_next = '0;
        if (count_reg != '0) begin
          pop           = 1'b1;
          shifter_next  = mem[rd_ptr_reg];
          byte_idx_next = 2'd0;
          state_next    = START;
        end
      end
      START: begin
        if (tick) begin
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_reg == 3'd7) begin
            stop_cnt_next = '0;
            state_next    = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt_reg != STOP_LAST) begin
            stop_cnt_next = stop_cnt_reg + SW'(1);
          end else if (byte_idx_reg != 2'd3) begin
            byte_idx_next = byte_idx_reg + 2'd1;
            shifter_next  = {shifter_reg[23:0], 8'h00};
            state_next    = START;
          end else if (count_reg != '0) begin
            // chain straight into the next word so back-to-back words have no gap
            pop           = 1'b1;
            shifter_next  = mem[rd_ptr_reg];
            byte_idx_next = 2'd0;
            state_next    = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // txd is produced from the upcoming state so the line changes on the same edge
  assign cur_byte = shifter_next[31:24];

  always_comb begin
    txd_next = 1'b1;
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = cur_byte[3'd7 - bit_idx_next];
      default: txd_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE) || (count_next != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      state_reg    <= IDLE;
      shifter_reg  <= '0;
      byte_idx_reg <= '0;
      bit_idx_reg  <= '0;
      clk_cnt_reg  <= '0;
      stop_cnt_reg <= '0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      state_reg    <= state_next;
      shifter_reg  <= shifter_next;
      byte_idx_reg <= byte_idx_next;
      bit_idx_reg  <= bit_idx_next;
      clk_cnt_reg  <= clk_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      txd_reg      <= txd_next;
      busy_reg     <= busy_next;
    end
  end

endmodule
